// File: rtl/wb_sram.sv
// wb_sram: Wishbone classic (non-pipelined) single-port SRAM responder.
// Each request passes through IDLE -> [WAIT x WAIT_STATES] -> RESP. RESP
// terminates the request for exactly one cycle. Writes honour the byte-lane
// selects and are committed at the clock edge that ends RESP.
// Optional build macro WB_SRAM_ADDR_ERR_EN: a request with any address bit
// above the memory range set ends with err_o and performs no access.
// Without the macro those bits are ignored, so such addresses alias into
// the array.
module wb_sram #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [31:0] adr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    output logic        ack_o,
    output logic        err_o,
    output logic        rty_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    // The counter is loaded with WAIT_STATES-1, so the final WAIT cycle is
    // the one that sees zero.
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   adr_q;
    logic [3:0]              sel_q;
    logic [31:0]             wdat_q;
    logic                    addr_err_q;
    logic                    ack_q;
    logic                    err_q;
    logic                    rd_en_q;
    logic [31:0]             rd_data_q;
    logic [31:0]             mem [DEPTH];

    logic                    req;
    logic                    addr_err;
    logic [ADDR_WIDTH-1:0]   rd_idx;
    logic                    wr_en;
    logic                    unused_adr;

    assign req = cyc_i & stb_i;

`ifdef WB_SRAM_ADDR_ERR_EN
    assign addr_err   = |adr_i[31:ADDR_WIDTH+2];
    assign unused_adr = ^adr_i[1:0];
`else
    assign addr_err   = 1'b0;
    assign unused_adr = ^{adr_i[31:ADDR_WIDTH+2], adr_i[1:0]};
`endif

    // The array is read on the edge that enters RESP. With zero wait states
    // that edge is also the request edge, so the live address is used in IDLE.
    assign rd_idx = (state_q == IDLE) ? adr_i[ADDR_WIDTH+1:2] : adr_q;

    // Gating with rst_i keeps a reset that lands in RESP from writing.
    assign wr_en = rst_i && (state_q == RESP) && we_q && !addr_err_q;

    // Request FSM with registered terminations; the outputs are cleared
    // every cycle unless a transition into RESP sets them.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rd_en_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rd_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        we_q       <= we_i;
                        adr_q      <= adr_i[ADDR_WIDTH+1:2];
                        sel_q      <= sel_i;
                        wdat_q     <= dat_i;
                        addr_err_q <= addr_err;
                        if (WAIT_STATES == 0) begin
                            state_q <= RESP;
                            ack_q   <= !addr_err;
                            err_q   <= addr_err;
                            rd_en_q <= !we_i && !addr_err;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (!req) begin
                        // The master abandoned the cycle: drop it silently.
                        state_q <= IDLE;
                        cnt_q   <= 4'd0;
                    end else if (cnt_q == 4'd0) begin
                        state_q <= RESP;
                        ack_q   <= !addr_err_q;
                        err_q   <= addr_err_q;
                        rd_en_q <= !we_q && !addr_err_q;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Memory array: registered read every cycle and a byte-masked write.
    // The array has no reset.
    always_ff @(posedge clk_i) begin
        rd_data_q <= mem[rd_idx];
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (sel_q[b]) begin
                    mem[adr_q][8*b +: 8] <= wdat_q[8*b +: 8];
                end
            end
        end
    end

    assign dat_o = rd_en_q ? rd_data_q : 32'd0;
    assign ack_o = ack_q;
    assign err_o = err_q;
    assign rty_o = 1'b0;

endmodule

// File: tb/tb_wb_sram.sv
// tb_wb_sram: directed self-checking bench for wb_sram.
// Two instances are used. dut0 has WAIT_STATES=1 and dut1 has WAIT_STATES=3.
// Both share reset and the data/address inputs, and each has its own
// cyc/stb pair. The expected value for the upper-address test depends on
// whether WB_SRAM_ADDR_ERR_EN is defined.
module tb_wb_sram;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc_a, stb_a, cyc_b, stb_b;
    logic        we;
    logic [31:0] adr, wdat;
    logic [3:0]  sel;
    logic [31:0] dat_a, dat_b;
    logic        ack_a, err_a, rty_a, ack_b, err_b, rty_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_sram #(.ADDR_WIDTH(10), .WAIT_STATES(1)) u_dut_ws1 (
        .clk_i(clk), .rst_i(rst_n), .cyc_i(cyc_a), .stb_i(stb_a), .we_i(we),
        .adr_i(adr), .sel_i(sel), .dat_i(wdat), .dat_o(dat_a),
        .ack_o(ack_a), .err_o(err_a), .rty_o(rty_a)
    );

    wb_sram #(.ADDR_WIDTH(10), .WAIT_STATES(3)) u_dut_ws3 (
        .clk_i(clk), .rst_i(rst_n), .cyc_i(cyc_b), .stb_i(stb_b), .we_i(we),
        .adr_i(adr), .sel_i(sel), .dat_i(wdat), .dat_o(dat_b),
        .ack_o(ack_b), .err_o(err_b), .rty_o(rty_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic f_ack(input int d);
        return (d == 0) ? ack_a : ack_b;
    endfunction

    function automatic logic f_err(input int d);
        return (d == 0) ? err_a : err_b;
    endfunction

    function automatic logic f_rty(input int d);
        return (d == 0) ? rty_a : rty_b;
    endfunction

    function automatic logic [31:0] f_dat(input int d);
        return (d == 0) ? dat_a : dat_b;
    endfunction

    task automatic set_req(input int d, input logic v);
        if (d == 0) begin
            cyc_a = v;
            stb_a = v;
        end else begin
            cyc_b = v;
            stb_b = v;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transfer. It checks that the termination arrives
    // WAIT_STATES+1 edges after the request is raised, that it is one cycle
    // wide, and that dat_o is 0 outside the termination cycle.
    task automatic xfer(input int d, input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] wd, input string tag,
                        output logic [31:0] rd, output logic er);
        int n;
        int exp_lat;
        logic term;
        exp_lat = (d == 0) ? 2 : 4;
        we = w; adr = a; sel = s; wdat = wd;
        set_req(d, 1'b1);
        n = 0;
        term = 1'b0;
        while (!term && n < 20) begin
            tick();
            n++;
            term = f_ack(d) | f_err(d);
            if (!term) check({tag, "_dat_before"}, f_dat(d), 32'd0);
        end
        check({tag, "_latency"}, n, exp_lat);
        rd = f_dat(d);
        er = f_err(d);
        check({tag, "_rty"}, {31'd0, f_rty(d)}, 32'd0);
        set_req(d, 1'b0);
        tick();
        check({tag, "_term_width"}, {30'd0, f_ack(d), f_err(d)}, 32'd0);
        check({tag, "_dat_after"}, f_dat(d), 32'd0);
        $display("xfer %s dut%0d we=%0b adr=%h sel=%b wdat=%h rdat=%h err=%0b lat=%0d",
                 tag, d, w, a, s, wd, rd, er, n);
    endtask

    logic [31:0] rd;
    logic        er;
    logic        held_exp [5];

    initial begin
        rst_n = 1'b0;
        cyc_a = 1'b0; stb_a = 1'b0; cyc_b = 1'b0; stb_b = 1'b0;
        we = 1'b0; adr = 32'd0; wdat = 32'd0; sel = 4'd0;

        // Reset held low for one edge.
        tick();
        rst_n = 1'b1;
        check("rst_ack0", {31'd0, ack_a}, 32'd0);
        check("rst_err0", {31'd0, err_a}, 32'd0);
        check("rst_rty0", {31'd0, rty_a}, 32'd0);
        check("rst_dat0", dat_a, 32'd0);
        check("rst_ack1", {31'd0, ack_b}, 32'd0);
        check("rst_dat1", dat_b, 32'd0);
        tick();

        // Full write, then read back.
        xfer(0, 1'b1, 32'h4, 4'hF, 32'hDEADBEEF, "wr_full", rd, er);
        check("wr_full_noerr", {31'd0, er}, 32'd0);
        xfer(0, 1'b0, 32'h4, 4'hF, 32'h0, "rd_full", rd, er);
        check("rd_full_data", rd, 32'hDEADBEEF);

        // Lane 0 only.
        xfer(0, 1'b1, 32'h4, 4'b0001, 32'h000000AA, "wr_lane0", rd, er);
        xfer(0, 1'b0, 32'h4, 4'b0000, 32'h0, "rd_lane0", rd, er);
        check("rd_lane0_data", rd, 32'hDEADBEAA);

        // sel=0000 write is acknowledged but leaves memory unchanged.
        xfer(0, 1'b1, 32'h4, 4'b0000, 32'hFFFFFFFF, "wr_nosel", rd, er);
        check("wr_nosel_noerr", {31'd0, er}, 32'd0);
        // adr[1:0] is ignored.
        xfer(0, 1'b0, 32'h7, 4'hF, 32'h0, "rd_nosel", rd, er);
        check("rd_nosel_data", rd, 32'hDEADBEAA);

        // WAIT_STATES=3: a write abandoned in WAIT produces no termination
        // and does not write.
        xfer(1, 1'b1, 32'h8, 4'hF, 32'h11112222, "ws3_wr", rd, er);
        we = 1'b1; adr = 32'h8; wdat = 32'h12345678; sel = 4'hF;
        set_req(1, 1'b1);
        tick();
        set_req(1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort_noack", {30'd0, ack_b, err_b}, 32'd0);
        end
        $display("xfer abort dut1 we=1 adr=00000008 dropped after 1 cycle");
        xfer(1, 1'b0, 32'h8, 4'hF, 32'h0, "ws3_rd", rd, er);
        check("abort_data_kept", rd, 32'h11112222);

        // Upper address bits: error termination or aliasing onto word 0.
        xfer(0, 1'b1, 32'h0, 4'hF, 32'hCAFE0000, "wr_word0", rd, er);
        we = 1'b0; adr = 32'h1000; sel = 4'hF;
        set_req(0, 1'b1);
        tick();
        check("hi_adr_wait", {30'd0, ack_a, err_a}, 32'd0);
        tick();
`ifdef WB_SRAM_ADDR_ERR_EN
        check("hi_adr_err", {31'd0, err_a}, 32'd1);
        check("hi_adr_ack", {31'd0, ack_a}, 32'd0);
        check("hi_adr_dat", dat_a, 32'd0);
`else
        check("hi_adr_err", {31'd0, err_a}, 32'd0);
        check("hi_adr_ack", {31'd0, ack_a}, 32'd1);
        check("hi_adr_dat", dat_a, 32'hCAFE0000);
`endif
        set_req(0, 1'b0);
        tick();
        check("hi_adr_width", {30'd0, ack_a, err_a}, 32'd0);
        $display("xfer hi_adr dut0 we=0 adr=00001000 ack=%0b err=%0b", ack_a, err_a);

        // Reset during WAIT of a write to 0xC.
        xfer(1, 1'b1, 32'hC, 4'hF, 32'hA5A5A5A5, "ws3_wr_c", rd, er);
        we = 1'b1; adr = 32'hC; wdat = 32'h5A5A5A5A; sel = 4'hF;
        set_req(1, 1'b1);
        tick();
        rst_n = 1'b0;
        tick();
        check("rstw_ack", {31'd0, ack_b}, 32'd0);
        check("rstw_err", {31'd0, err_b}, 32'd0);
        check("rstw_rty", {31'd0, rty_b}, 32'd0);
        check("rstw_dat", dat_b, 32'd0);
        rst_n = 1'b1;
        set_req(1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rstw_noack", {31'd0, ack_b}, 32'd0);
        end
        $display("xfer rst_in_wait dut1 we=1 adr=0000000c reset asserted in WAIT");
        xfer(1, 1'b0, 32'hC, 4'hF, 32'h0, "rstw_rd", rd, er);
        check("rstw_data_kept", rd, 32'hA5A5A5A5);
        // The array has no reset: dut0 contents survive it.
        xfer(0, 1'b0, 32'h4, 4'hF, 32'h0, "rd_after_rst", rd, er);
        check("rd_after_rst_data", rd, 32'hDEADBEAA);

        // Request held across termination: it is taken again in the IDLE
        // cycle after RESP, so acks are 3 cycles apart.
        held_exp = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        we = 1'b0; adr = 32'h4; sel = 4'hF;
        set_req(0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("held_ack%0d", i), {31'd0, ack_a}, {31'd0, held_exp[i]});
            check($sformatf("held_dat%0d", i), dat_a, held_exp[i] ? 32'hDEADBEAA : 32'd0);
        end
        set_req(0, 1'b0);
        tick();
        check("held_end", {31'd0, ack_a}, 32'd0);
        $display("xfer held dut0 we=0 adr=00000004 two back-to-back reads");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
